// File: rtl/pool_flatten_streamer_pkg.sv
// Shared constants and state type for the pooled-frame flattener.
// The FC layer consumes FLAT_LEN words of OF_BW bits, indexed with IDX_BW bits.
package pool_flatten_streamer_pkg;

  localparam int CI       = 3;
  localparam int P_SIZE   = 4;
  localparam int OF_BW    = 32;
  localparam int FLAT_LEN = CI * P_SIZE * P_SIZE;
  localparam int IDX_BW   = $clog2(FLAT_LEN);

  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(FLAT_LEN - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/pool_flatten_streamer.sv
// Captures a parallel pooled frame and replays it as a flattened valid/ready
// word stream with a last flag; strobes arriving while busy are dropped and counted.
module pool_flatten_streamer
  import pool_flatten_streamer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_in_valid,
  input  logic [FLAT_LEN*OF_BW-1:0] i_in_fmap,
  output logic                      o_in_ready,
  output logic                      o_ot_valid,
  input  logic                      i_ot_ready,
  output logic [OF_BW-1:0]          o_ot_data,
  output logic [IDX_BW-1:0]         o_ot_idx,
  output logic                      o_ot_last,
  output logic                      o_drop,
  output logic [7:0]                o_drop_cnt
);

  state_t                    state_reg;
  logic [IDX_BW-1:0]         idx_reg;
  logic [FLAT_LEN*OF_BW-1:0] buf_reg;
  logic                      drop_reg;
  logic [7:0]                drop_cnt_reg;

  logic streaming;
  logic at_last;
  logic beat;
  logic capture;
  logic discard;

  assign streaming = (state_reg == ST_STREAM);
  assign at_last   = (idx_reg == LAST_IDX);
  assign beat      = streaming & i_ot_ready;

  // Ready opens on the final beat so a strobe aligned with it chains without a bubble.
  assign o_in_ready = ~streaming | (at_last & i_ot_ready);
  assign capture    = i_in_valid & o_in_ready;
  assign discard    = i_in_valid & ~o_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      buf_reg      <= '0;
      drop_reg     <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      drop_reg <= discard;
      if (discard && drop_cnt_reg != 8'hFF) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end

      if (capture) begin
        buf_reg <= i_in_fmap;
      end

      case (state_reg)
        ST_IDLE: begin
          if (capture) begin
            idx_reg   <= '0;
            state_reg <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (beat) begin
            if (at_last) begin
              idx_reg   <= '0;
              state_reg <= capture ? ST_STREAM : ST_IDLE;
            end else begin
              idx_reg <= idx_reg + IDX_BW'(1);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          idx_reg   <= '0;
        end
      endcase
    end
  end

  // Outputs come only from state, idx and buffer registers.
  assign o_ot_valid = streaming;
  assign o_ot_idx   = streaming ? idx_reg : '0;
  assign o_ot_last  = streaming & at_last;
  assign o_ot_data  = streaming ? buf_reg[int'(idx_reg) * OF_BW +: OF_BW] : '0;
  assign o_drop     = drop_reg;
  assign o_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_pool_flatten_streamer.sv
// Directed bench for pool_flatten_streamer: a frame-level model checks every cycle,
// and literal expectations pin sequences, gaps, drops, saturation and reset.
module tb_pool_flatten_streamer;
  import pool_flatten_streamer_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      i_in_valid;
  logic [FLAT_LEN*OF_BW-1:0] i_in_fmap;
  logic                      o_in_ready;
  logic                      o_ot_valid;
  logic                      i_ot_ready;
  logic [OF_BW-1:0]          o_ot_data;
  logic [IDX_BW-1:0]         o_ot_idx;
  logic                      o_ot_last;
  logic                      o_drop;
  logic [7:0]                o_drop_cnt;

  pool_flatten_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .i_in_valid (i_in_valid),
    .i_in_fmap  (i_in_fmap),
    .o_in_ready (o_in_ready),
    .o_ot_valid (o_ot_valid),
    .i_ot_ready (i_ot_ready),
    .o_ot_data  (o_ot_data),
    .o_ot_idx   (o_ot_idx),
    .o_ot_last  (o_ot_last),
    .o_drop     (o_drop),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: the held frame, the element position, and the drop bookkeeping.
  bit          started = 0;
  bit          m_active = 0;
  int unsigned m_frame [FLAT_LEN];
  int          m_k = 0;
  int          m_cnt = 0;
  bit          m_drop = 0;

  int cyc = 0;
  int log_data[$];
  bit log_last[$];
  int log_cyc[$];
  int drop_pulses = 0;

  always @(negedge clk) begin
    bit exp_rdy;
    cyc++;
    if (started) begin
      exp_rdy = !m_active || (m_k == FLAT_LEN - 1 && i_ot_ready);
      chk("ot_valid", o_ot_valid, m_active);
      chk("in_ready", o_in_ready, exp_rdy);
      chk("drop", o_drop, m_drop);
      chk("drop_cnt", o_drop_cnt, m_cnt);
      if (m_active) begin
        chk("ot_data", o_ot_data, m_frame[m_k]);
        chk("ot_idx", o_ot_idx, m_k);
        chk("ot_last", o_ot_last, m_k == FLAT_LEN - 1);
      end
      if (o_drop) drop_pulses++;
      if (o_ot_valid && i_ot_ready) begin
        log_data.push_back(int'(o_ot_data));
        log_last.push_back(o_ot_last);
        log_cyc.push_back(cyc);
        if (o_ot_last) $display("frame done: last element %0d at cycle %0d", o_ot_data, cyc);
      end

      if (reset) begin
        m_active = 0;
        m_k      = 0;
        m_cnt    = 0;
        m_drop   = 0;
        foreach (m_frame[k]) m_frame[k] = 0;
      end else begin
        m_drop = i_in_valid && !exp_rdy;
        if (m_drop && m_cnt < 255) m_cnt++;
        if (m_active && i_ot_ready) begin
          if (m_k == FLAT_LEN - 1) m_active = 0;
          else m_k++;
        end
        if (i_in_valid && exp_rdy) begin
          foreach (m_frame[k]) m_frame[k] = i_in_fmap[k*OF_BW +: OF_BW];
          m_k      = 0;
          m_active = 1;
        end
      end
    end
  end

  function automatic logic [FLAT_LEN*OF_BW-1:0] make_frame(input int base);
    logic [FLAT_LEN*OF_BW-1:0] f;
    for (int k = 0; k < FLAT_LEN; k++) f[k*OF_BW +: OF_BW] = OF_BW'(base + k);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs for one cycle: strobe carries a frame, otherwise the bus holds junk.
  task automatic drive(input bit vld, input int base, input bit rdy);
    i_in_valid = vld;
    i_in_fmap  = vld ? make_frame(base) : {FLAT_LEN{32'hDEAD_BEEF}};
    i_ot_ready = rdy;
    tick();
  endtask

  function automatic int seq_errors(input int first, input int base);
    int n = 0;
    for (int i = 0; i < FLAT_LEN; i++)
      if (first + i >= log_data.size() || log_data[first + i] != base + i) n++;
    return n;
  endfunction

  initial begin
    reset      = 1'b1;
    i_in_valid = 1'b0;
    i_in_fmap  = '0;
    i_ot_ready = 1'b0;
    tick();
    tick();
    started = 1;
    chk("rst_valid", o_ot_valid, 0);
    chk("rst_data", o_ot_data, 0);
    chk("rst_idx", o_ot_idx, 0);
    chk("rst_last", o_ot_last, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_drop_cnt", o_drop_cnt, 0);
    chk("rst_in_ready", o_in_ready, 1);
    reset = 1'b0;
    tick();

    // Straight frame, ready held high.
    log_data.delete(); log_last.delete(); log_cyc.delete();
    drive(1, 1, 1);
    repeat (55) drive(0, 0, 1);
    chk("t1_beats", log_data.size(), 48);
    chk("t1_first", log_data[0], 1);
    chk("t1_last_data", log_data[47], 48);
    chk("t1_last_flag", log_last[47], 1);
    chk("t1_not_last_46", log_last[46], 0);
    chk("t1_span", log_cyc[47] - log_cyc[0], 47);
    chk("t1_idle", o_ot_valid, 0);

    // Ready toggled 1,0,0 repeating.
    log_data.delete(); log_last.delete(); log_cyc.delete();
    for (int c = 0; c < 48 * 3 + 12; c++) drive(c == 0, 1, (c % 3) == 0);
    chk("t2_beats", log_data.size(), 48);
    chk("t2_seq_errs", seq_errors(0, 1), 0);

    // Second strobe aligned with the last beat chains with no gap.
    log_data.delete(); log_last.delete(); log_cyc.delete();
    for (int c = 0; c < 110; c++) drive(c == 0 || c == 48, (c == 0) ? 1 : 100, 1);
    chk("t3_beats", log_data.size(), 96);
    chk("t3_seq1_errs", seq_errors(0, 1), 0);
    chk("t3_seq2_first", log_data[48], 100);
    chk("t3_seq2_errs", seq_errors(48, 100), 0);
    chk("t3_no_gap", log_cyc[48] - log_cyc[47], 1);
    chk("t3_no_drop", o_drop_cnt, 0);

    // Strobe at idx 10 is dropped; stream carries on.
    log_data.delete(); log_last.delete(); log_cyc.delete();
    drop_pulses = 0;
    for (int c = 0; c < 60; c++) drive(c == 0 || c == 11, (c == 0) ? 1 : 500, 1);
    chk("t4_drop_cnt", o_drop_cnt, 1);
    chk("t4_drop_pulses", drop_pulses, 1);
    chk("t4_beats", log_data.size(), 48);
    chk("t4_seq_errs", seq_errors(0, 1), 0);

    // 300 strobes while stalled saturate the counter.
    drive(1, 1, 0);
    repeat (300) drive(1, 900, 0);
    drive(0, 0, 0);
    chk("t5_drop_cnt_sat", o_drop_cnt, 255);
    repeat (55) drive(0, 0, 1);

    // Reset at idx 20 together with a strobe.
    drive(1, 1, 1);
    repeat (20) drive(0, 0, 1);
    chk("t6_idx_before_rst", o_ot_idx, 20);
    reset = 1'b1;
    drive(1, 700, 1);
    reset = 1'b0;
    chk("t6_valid_after_rst", o_ot_valid, 0);
    chk("t6_cnt_after_rst", o_drop_cnt, 0);
    chk("t6_ready_after_rst", o_in_ready, 1);
    log_data.delete(); log_last.delete(); log_cyc.delete();
    drive(1, 200, 1);
    repeat (55) drive(0, 0, 1);
    chk("t6_first", log_data[0], 200);
    chk("t6_beats", log_data.size(), 48);
    chk("t6_seq_errs", seq_errors(0, 200), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_flatten_streamer.md
# pool_flatten_streamer

Downstream neighbour of the max-pooling stage. Captures one pooled feature-map frame (CI × P_SIZE × P_SIZE words, all parallel) on the pooling stage's valid pulse. Replays it as a serial, flattened word stream with valid/ready handshake and a last flag, feeding the fully-connected layer. Frames that arrive while a stream is in progress, and cannot be accepted, are dropped and counted.

## Interface
- CI, `CI (3): channel count of the pooled frame.
- P_SIZE, `P_SIZE (4): pooled frame height and width.
- OF_BW, `OF_BW (32): bits per element.
- FLAT_LEN, CI*P_SIZE*P_SIZE (48): elements per frame.
- IDX_BW, $clog2(FLAT_LEN) (6): element index width.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- i_in_valid  in  1  one-cycle frame strobe from pooling stage; no backpressure upstream.
- i_in_fmap  in  FLAT_LEN*OF_BW  pooled frame; element k at bits [OF_BW*k +: OF_BW], k = (ci*P_SIZE+row)*P_SIZE+col.
- o_in_ready  out  1  high when a frame strobe this cycle will be captured.
- o_ot_valid  out  1  output element valid.
- i_ot_ready  in  1  downstream accepts element.
- o_ot_data  out  OF_BW  current element.
- o_ot_idx  out  IDX_BW  flat index k of o_ot_data.
- o_ot_last  out  1  high with o_ot_valid when k = FLAT_LEN-1.
- o_drop  out  1  one-cycle pulse when a strobed frame is discarded.
- o_drop_cnt  out  8  saturating count of dropped frames.

## Operation
- States: IDLE, STREAM.
- Beat = o_ot_valid & i_ot_ready.
- IDLE: o_in_ready=1. On i_in_valid, latch i_in_fmap into frame buffer, set idx=0, go to STREAM.
- STREAM: o_ot_valid=1, o_ot_data = buffer element idx, o_ot_idx=idx, o_ot_last=(idx==FLAT_LEN-1).
  - On a beat with idx<FLAT_LEN-1: idx+1.
  - On a beat with idx==FLAT_LEN-1 (last beat): frame complete. If i_in_valid in the same cycle, capture the new frame, idx=0, stay in STREAM (back-to-back, no bubble). Otherwise go to IDLE.
  - Without a beat: hold idx, data, and last stable. o_ot_valid must not drop.
- o_in_ready = (state==IDLE) | (state==STREAM & idx==FLAT_LEN-1 & i_ot_ready). Combinational from i_ot_ready.
- i_in_valid & !o_in_ready: frame discarded, o_drop=1 next cycle, o_drop_cnt+1 saturating at 255. The in-progress stream is unaffected.
- Elements pass unmodified (no sign or width conversion). Element order is strictly increasing k: channel-major, then row, then column.
- i_in_fmap is sampled only on the capture cycle. The buffer is not written at any other time.

## Timing
- Reset values:
  - state=IDLE, idx=0.
  - o_ot_valid=0, o_ot_last=0, o_ot_data=0, o_ot_idx=0.
  - o_drop=0, o_drop_cnt=0.
  - Frame buffer cleared to 0.
- Latency: capture at edge t → o_ot_valid=1 with element 0 from cycle t+1.
- Minimum frame period with i_ot_ready held high: FLAT_LEN cycles. Frames strobed every 48 cycles, aligned to the last beat, stream with zero gap.
- o_ot_data, o_ot_idx, and o_ot_last are registered or driven from registered idx/buffer only. The sole combinational path from i_ot_ready is to o_in_ready.
- Reset mid-stream: the next cycle shows o_ot_valid=0 and IDLE. The partial frame is lost without counting as a drop. A strobe in the same cycle as reset is ignored.
- o_drop is a single-cycle registered pulse, one per discarded strobe.

## Structure
- In the shared defines_cnn_core.vh: FLAT_LEN and FLAT_IDX_BW macros beside `CI, `P_SIZE, `OF_BW. The FC layer uses the same constants.
- State encoding as localparams inside the module.
- No sub-module. Element selection is one indexed part-select on the buffer. Estimated size: roughly 150 lines.

## Test plan
- Frame with element k = k+1, i_ot_ready=1 → 48 beats over cycles t+1..t+48, data 1..48, idx 0..47, o_ot_last only on the beat with data 48, then IDLE.
- Same frame, i_ot_ready toggled 1,0,0,1,… → data/idx held while not ready, exact sequence 1..48 with no loss or duplication.
- Second strobe aligned with last beat (data 48 handshaking) carrying 100+k → next cycle o_ot_data=100, no gap, no drop.
- Strobe at idx=10 mid-stream → o_drop pulses once, o_drop_cnt=1, current stream continues unchanged to element 47.
- 300 drop-inducing strobes → o_drop_cnt saturates at 255.
- reset asserted at idx=20 together with i_in_valid → next cycle o_ot_valid=0, IDLE, o_drop_cnt=0; a later strobe streams from element 0.
